// File: rtl/ppm_final_adder.sv
// ppm_final_adder: carry-propagate adder behind the PPM partial-product multiplier.
//
// Adds the redundant pair in1/in2 into a single W = N+M bit product, modulo 2^W.
// The add is split into SEG-bit segments, one pipeline stage per segment, so a
// ripple carry never crosses more than SEG bits in one cycle. Each stage forwards
// the operand bits still to be added, the sum bits already formed, and its carry.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   in1/in2 hold a valid operand pair
//   in_ready   stage accepts input this cycle (low only while the output stalls)
//   in1, in2   redundant operands (PPM out1/out2), W bits
//   out_valid  result holds a valid sum
//   out_ready  downstream consumes result this cycle
//   result     (in1 + in2) mod 2^W
module ppm_final_adder #(
    parameter int unsigned N   = 8,
    parameter int unsigned M   = 8,
    parameter int unsigned SEG = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N+M-1:0] in1,
    input  logic [N+M-1:0] in2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N+M-1:0] result
);

    localparam int unsigned W      = N + M;
    localparam int unsigned STAGES = (W + SEG - 1) / SEG;

    // The whole pipeline freezes as one unit; bubbles are never collapsed.
    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            localparam int unsigned LO  = k * SEG;
            localparam int unsigned WID = ((W - LO) < SEG) ? (W - LO) : SEG;
            localparam int unsigned HI  = LO + WID;
            // Operand bits entering this stage that have not been added yet.
            localparam int unsigned RW  = W - LO;

            logic [RW-1:0]  a_in;
            logic [RW-1:0]  b_in;
            logic           cin;
            logic           vin;
            logic [WID-1:0] seg;
            logic [HI-1:0]  s_d;
            logic [HI-1:0]  s_q;
            logic           v_q;

            if (k == 0) begin : g_head
                assign a_in = in1;
                assign b_in = in2;
                assign cin  = 1'b0;
                assign vin  = in_valid;
                assign s_d  = seg;
            end else begin : g_body
                assign a_in = g_stage[k-1].g_fwd.a_q;
                assign b_in = g_stage[k-1].g_fwd.b_q;
                assign cin  = g_stage[k-1].g_fwd.c_q;
                assign vin  = g_stage[k-1].v_q;
                assign s_d  = {seg, g_stage[k-1].s_q};
            end

            if (HI < W) begin : g_fwd
                logic [WID:0]      seg_sum;
                logic [RW-WID-1:0] a_q;
                logic [RW-WID-1:0] b_q;
                logic              c_q;

                assign seg_sum = {1'b0, a_in[WID-1:0]} + {1'b0, b_in[WID-1:0]}
                               + (WID + 1)'(cin);
                assign seg     = seg_sum[WID-1:0];

                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_q <= '0;
                        b_q <= '0;
                        c_q <= 1'b0;
                    end else if (!stall) begin
                        a_q <= a_in[RW-1:WID];
                        b_q <= b_in[RW-1:WID];
                        c_q <= seg_sum[WID];
                    end
                end
            end else begin : g_tail
                // Top segment: the final carry-out is discarded (modulo-2^W add).
                assign seg = a_in + b_in + WID'(cin);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                    s_q <= '0;
                end else if (!stall) begin
                    v_q <= vin;
                    s_q <= s_d;
                end
            end
        end
    endgenerate

    assign result    = g_stage[STAGES-1].s_q;
    assign out_valid = g_stage[STAGES-1].v_q;

endmodule

// File: tb/tb_ppm_final_adder.sv
// Directed testbench for ppm_final_adder with N=M=8, SEG=4 (W=16, four stages).
// Inputs change 1 time unit after the rising edge; outputs are checked 2-3 units
// after the edge, well away from the next active edge.
module tb_ppm_final_adder;

    localparam int N      = 8;
    localparam int M      = 8;
    localparam int SEG    = 4;
    localparam int W      = N + M;
    localparam int STAGES = (W + SEG - 1) / SEG;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ppm_final_adder #(
        .N   (N),
        .M   (M),
        .SEG (SEG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in1       = 16'h1234;
        in2       = 16'h1111;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_out_valid cyc=%0d got=%b exp=0", i, out_valid);
            end
            total++;
            if (result !== 16'h0000) begin
                bad++;
                $display("FAIL reset_result cyc=%0d got=%h exp=0000", i, result);
            end
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL reset_in_ready cyc=%0d got=%b exp=1", i, in_ready);
            end
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_leak cyc=%0d got=%b exp=0", i, out_valid);
            end
        end
    endtask

    task automatic test_carry_ripple();
        logic [W-1:0] va [2];
        logic [W-1:0] vb [2];
        logic [W-1:0] ve [2];
        va[0] = 16'h00FF; vb[0] = 16'h0001; ve[0] = 16'h0100;
        va[1] = 16'h0FFF; vb[1] = 16'h0001; ve[1] = 16'h1000;
        for (int i = 0; i < 2; i++) begin
            in1       = va[i];
            in2       = vb[i];
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #2;
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL ripple_in_ready vec=%0d got=%b exp=1", i, in_ready);
            end
            step();
            in_valid = 1'b0;
            for (int j = 1; j < STAGES; j++) begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL ripple_early vec=%0d edge=%0d got=%b exp=0", i, j, out_valid);
                end
                step();
            end
            total++;
            if (out_valid !== 1'b1 || result !== ve[i]) begin
                bad++;
                $display("FAIL ripple_sum vec=%0d got v=%b r=%h exp v=1 r=%h",
                         i, out_valid, result, ve[i]);
            end
            step();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL ripple_drain vec=%0d got=%b exp=0", i, out_valid);
            end
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] va [2];
        logic [W-1:0] vb [2];
        va[0] = 16'hFFFF; vb[0] = 16'h0001;
        va[1] = 16'h8000; vb[1] = 16'h8000;
        for (int i = 0; i < 2; i++) begin
            in1       = va[i];
            in2       = vb[i];
            in_valid  = 1'b1;
            out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            for (int j = 1; j < STAGES; j++) begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL wrap_early vec=%0d edge=%0d got=%b exp=0", i, j, out_valid);
                end
                step();
            end
            total++;
            if (out_valid !== 1'b1 || result !== 16'h0000) begin
                bad++;
                $display("FAIL wrap_sum vec=%0d got v=%b r=%h exp v=1 r=0000",
                         i, out_valid, result);
            end
            step();
        end
    endtask

    // Redundant pairs whose sums are 200*150, 255*255, 3*7 and 0*99.
    task automatic test_back_to_back();
        logic [W-1:0] va [4];
        logic [W-1:0] vb [4];
        logic [W-1:0] ve [4];
        int nout;
        va[0] = 16'h7000; vb[0] = 16'h0530; ve[0] = 16'd30000;
        va[1] = 16'hF0F0; vb[1] = 16'h0D11; ve[1] = 16'd65025;
        va[2] = 16'hFFFF; vb[2] = 16'h0016; ve[2] = 16'd21;
        va[3] = 16'hABCD; vb[3] = 16'h5433; ve[3] = 16'd0;
        nout      = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_valid = (cyc < 4);
            if (cyc < 4) begin
                in1 = va[cyc];
                in2 = vb[cyc];
            end
            step();
            if (out_valid === 1'b1) begin
                total++;
                if (nout >= 4) begin
                    bad++;
                    $display("FAIL b2b_extra cyc=%0d got=%h exp=none", cyc, result);
                end else if (result !== ve[nout] || cyc != nout + STAGES - 1) begin
                    bad++;
                    $display("FAIL b2b_sum idx=%0d cyc=%0d got=%0d exp=%0d at cyc=%0d",
                             nout, cyc, result, ve[nout], nout + STAGES - 1);
                end
                nout++;
            end
        end
        in_valid = 1'b0;
        total++;
        if (nout != 4) begin
            bad++;
            $display("FAIL b2b_count got=%0d exp=4", nout);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] va [6];
        logic [W-1:0] vb [6];
        logic [W-1:0] ve [6];
        logic [W-1:0] held;
        int  nin;
        int  nout;
        int  stall_left;
        bit  stalled;
        bit  acc;
        va[0] = 16'h00FF; vb[0] = 16'h0001; ve[0] = 16'h0100;
        va[1] = 16'h0FFF; vb[1] = 16'h0001; ve[1] = 16'h1000;
        va[2] = 16'h1234; vb[2] = 16'h4321; ve[2] = 16'h5555;
        va[3] = 16'h7FFF; vb[3] = 16'h7FFF; ve[3] = 16'hFFFE;
        va[4] = 16'hFFF0; vb[4] = 16'h0020; ve[4] = 16'h0010;
        va[5] = 16'h8888; vb[5] = 16'h7777; ve[5] = 16'hFFFF;
        nin        = 0;
        nout       = 0;
        stall_left = 0;
        stalled    = 1'b0;
        held       = '0;
        for (int cyc = 0; cyc < 40 && nout < 6; cyc++) begin
            if (out_valid === 1'b1 && !stalled) begin
                stalled    = 1'b1;
                stall_left = 3;
                held       = result;
            end
            out_ready = (stall_left == 0);
            in_valid  = (nin < 6);
            if (nin < 6) begin
                in1 = va[nin];
                in2 = vb[nin];
            end
            #2;
            if (stall_left > 0) begin
                total++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== held) begin
                    bad++;
                    $display("FAIL bp_hold cyc=%0d got rdy=%b v=%b r=%h exp rdy=0 v=1 r=%h",
                             cyc, in_ready, out_valid, result, held);
                end
                stall_left--;
            end else if (out_valid === 1'b1) begin
                total++;
                if (result !== ve[nout]) begin
                    bad++;
                    $display("FAIL bp_sum idx=%0d got=%h exp=%h", nout, result, ve[nout]);
                end
                nout++;
            end
            acc = in_valid && (in_ready === 1'b1);
            step();
            if (acc) nin++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (nout != 6 || nin != 6 || !stalled) begin
            bad++;
            $display("FAIL bp_count got out=%0d in=%0d stalled=%b exp 6 6 1", nout, nin, stalled);
        end
        for (int i = 0; i < 5; i++) begin
            #2;
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL bp_dup cyc=%0d got v=%b r=%h exp v=0", i, out_valid, result);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in1      = 16'h0101 * (i + 1);
            in2      = 16'h0F0F;
            step();
        end
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_full got=%b exp=1", out_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || result !== 16'h0000) begin
            bad++;
            $display("FAIL rstmid_clear got v=%b r=%h exp v=0 r=0000", out_valid, result);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_stale cyc=%0d got v=%b r=%h exp v=0", i, out_valid, result);
            end
        end
        in1      = 16'h0001;
        in2      = 16'h0002;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int j = 1; j < STAGES; j++) begin
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_early edge=%0d got=%b exp=0", j, out_valid);
            end
            step();
        end
        total++;
        if (out_valid !== 1'b1 || result !== 16'h0003) begin
            bad++;
            $display("FAIL rstmid_new got v=%b r=%h exp v=1 r=0003", out_valid, result);
        end
        step();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in1       = '0;
        in2       = '0;
        out_ready = 1'b1;
        #1;
        test_reset();
        test_carry_ripple();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
